// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction fetch front end.
//
// Generates block-aligned fetch addresses from the reset vector, the branch
// predictor or a backend mispredict redirect. Requests are pipelined and
// in-order, with at most BUF_DEPTH outstanding. Returned blocks land in a
// small circular fetch buffer. The buffer head is presented to decode with a
// valid/ready handshake. Responses that belong to requests made before a
// redirect or reset are counted in drop_cnt and then discarded.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_addr/rmask     request address (block aligned) and read mask
//   imem_ready          memory accepts the request this cycle
//   imem_resp/rdata     in-order response valid and block data
//   pc_at_fetch         current fetch PC, to the predictor
//   bp_taken/slot/target
//                       combinational prediction for the current block
//   branch_mispredict/branch_target
//                       backend redirect, highest priority
//   out_valid/ready     decode handshake
//   out_pc/insts/mask/branch_pred
//                       head block contents
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h6000_0000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   imem_addr,
  output logic [4*FETCH_WIDTH-1:0]      imem_rmask,
  input  logic                          imem_ready,
  input  logic                          imem_resp,
  input  logic [32*FETCH_WIDTH-1:0]     imem_rdata,
  output logic [31:0]                   pc_at_fetch,
  input  logic                          bp_taken,
  input  logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] bp_slot,
  input  logic [31:0]                   bp_target,
  input  logic                          branch_mispredict,
  input  logic [31:0]                   branch_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [32*FETCH_WIDTH-1:0]     out_insts,
  output logic [FETCH_WIDTH-1:0]        out_mask,
  output logic                          out_branch_pred
);

  localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0]   BLK_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FETCH_WIDTH - 1);

  // Architectural state
  logic [31:0]          pc_q, pc_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [PW-1:0]        fill_q, fill_d;          // oldest unfilled entry
  logic [CW-1:0]        alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]        unfilled_cnt_q, unfilled_cnt_d;
  logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
  logic [BUF_DEPTH-1:0] filled_q, filled_d;

  // Buffer payload (no reset needed: guarded by the counters and filled_q)
  logic [31:0]              ent_blk  [BUF_DEPTH];
  logic [FETCH_WIDTH-1:0]   ent_mask [BUF_DEPTH];
  logic                     ent_pred [BUF_DEPTH];
  logic [32*FETCH_WIDTH-1:0] ent_data [BUF_DEPTH];

  logic [31:0]          blk;
  logic [SW-1:0]        off;
  logic [SW-1:0]        lim;
  logic                 bp_hit;
  logic [FETCH_WIDTH-1:0] new_mask;
  logic [CW:0]          occupied;
  logic                 issue;
  logic                 fire;
  logic                 head_valid;
  logic                 pop;
  logic                 resp_drop;
  logic                 resp_fill;
  logic                 resp_used;
  logic [CW-1:0]        in_flight_after;

  assign blk = pc_q & ~(BLK_BYTES - 32'd1);

  generate
    if (FETCH_WIDTH > 1) begin : g_off
      assign off = pc_q[SW+1:2];
    end else begin : g_off_single
      assign off = '0;
    end
  endgenerate

  // A predicted branch in a slot before the entry point cannot be reached
  // from this PC, so it is treated as not taken.
  assign bp_hit = bp_taken && (bp_slot >= off);
  assign lim    = bp_hit ? bp_slot : LAST_SLOT;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_mask
      localparam logic [SW-1:0] SLOT = SW'(gi);
      assign new_mask[gi] = (off <= SLOT) && (SLOT <= lim);
    end
  endgenerate

  // Outstanding drops hold buffer credit so every response has a home.
  assign occupied   = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign issue      = !rst && !branch_mispredict && (occupied < (CW + 1)'(BUF_DEPTH));
  assign fire       = issue && imem_ready;
  assign head_valid = (alloc_cnt_q != '0) && filled_q[head_q];
  assign pop        = head_valid && out_ready;
  assign resp_drop  = imem_resp && (drop_cnt_q != '0);
  assign resp_fill  = imem_resp && (drop_cnt_q == '0) && (unfilled_cnt_q != '0);
  assign resp_used  = resp_drop || resp_fill;

  // Responses still owed by memory once this cycle's response is consumed.
  // Used when a redirect or reset abandons everything in flight.
  assign in_flight_after = unfilled_cnt_q + drop_cnt_q - CW'(resp_used);

  assign imem_addr       = blk;
  assign imem_rmask      = {(4 * FETCH_WIDTH){issue}};
  assign pc_at_fetch     = pc_q;
  assign out_valid       = head_valid;
  assign out_pc          = head_valid ? ent_blk[head_q]  : '0;
  assign out_insts       = head_valid ? ent_data[head_q] : '0;
  assign out_mask        = head_valid ? ent_mask[head_q] : '0;
  assign out_branch_pred = head_valid && ent_pred[head_q];

  always_comb begin
    pc_d           = pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    fill_d         = fill_q;
    alloc_cnt_d    = alloc_cnt_q;
    unfilled_cnt_d = unfilled_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    filled_d       = filled_q;

    if (branch_mispredict) begin
      // A same-cycle pop has already been consumed by decode, so clearing
      // the whole buffer is still correct.
      pc_d           = branch_target;
      head_d         = '0;
      tail_d         = '0;
      fill_d         = '0;
      alloc_cnt_d    = '0;
      unfilled_cnt_d = '0;
      drop_cnt_d     = in_flight_after;
      filled_d       = '0;
    end else begin
      if (fire) begin
        pc_d = bp_hit ? bp_target : (blk + BLK_BYTES);
      end
      tail_d         = tail_q + PW'(fire);
      head_d         = head_q + PW'(pop);
      fill_d         = fill_q + PW'(resp_fill);
      alloc_cnt_d    = alloc_cnt_q + CW'(fire) - CW'(pop);
      unfilled_cnt_d = unfilled_cnt_q + CW'(fire) - CW'(resp_fill);
      drop_cnt_d     = drop_cnt_q - CW'(resp_drop);
      if (pop) begin
        filled_d[head_q] = 1'b0;
      end
      if (fire) begin
        filled_d[tail_q] = 1'b0;
      end
      if (resp_fill) begin
        filled_d[fill_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      head_q         <= '0;
      tail_q         <= '0;
      fill_q         <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      // Requests issued before reset still return data. Those responses must be skipped.
      drop_cnt_q     <= in_flight_after;
      filled_q       <= '0;
    end else begin
      pc_q           <= pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      fill_q         <= fill_d;
      alloc_cnt_q    <= alloc_cnt_d;
      unfilled_cnt_q <= unfilled_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      filled_q       <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      ent_blk[tail_q]  <= blk;
      ent_mask[tail_q] <= new_mask;
      ent_pred[tail_q] <= bp_hit;
    end
    if (resp_fill) begin
      ent_data[fill_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed bench for fetch_pc_gen (FETCH_WIDTH=2, BUF_DEPTH=4).
// The memory model returns, for a block at address A, slot i = A + 4*i, with a
// programmable in-order latency.
module tb_fetch_pc_gen;

  localparam int FW = 2;
  localparam int BD = 4;
  localparam logic [31:0] RPC = 32'h6000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   imem_addr;
  logic [4*FW-1:0] imem_rmask;
  logic          imem_ready = 1'b0;
  logic          imem_resp = 1'b0;
  logic [32*FW-1:0] imem_rdata = '0;
  logic [31:0]   pc_at_fetch;
  logic          bp_taken = 1'b0;
  logic [0:0]    bp_slot = 1'b0;
  logic [31:0]   bp_target = '0;
  logic          branch_mispredict = 1'b0;
  logic [31:0]   branch_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [32*FW-1:0] out_insts;
  logic [FW-1:0] out_mask;
  logic          out_branch_pred;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];

  fetch_pc_gen #(.RESET_PC(RPC), .FETCH_WIDTH(FW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_ready(imem_ready),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .pc_at_fetch(pc_at_fetch), .bp_taken(bp_taken), .bp_slot(bp_slot),
    .bp_target(bp_target), .branch_mispredict(branch_mispredict),
    .branch_target(branch_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insts(out_insts), .out_mask(out_mask),
    .out_branch_pred(out_branch_pred)
  );

  always #5 clk = ~clk;

  // Memory model: record accepted requests, present in-order responses.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (imem_resp) void'(mq.pop_front());
    if (imem_rmask != '0 && imem_ready) mq.push_back('{imem_addr, cyc + mem_lat - 1});
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = {mq[0].addr + 32'd4, mq[0].addr};
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = '0;
    end
  end

  function automatic logic [63:0] blk_data(input logic [31:0] a);
    return {a + 32'd4, a};
  endfunction

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    branch_mispredict = 1'b1;
    branch_target = t;
    next();
    branch_mispredict = 1'b0;
  endtask

  task automatic quiesce();
    imem_ready = 1'b0;
    out_ready = 1'b1;
    bp_taken = 1'b0;
    repeat (12) next();
  endtask

  task automatic test_reset();
    next();
    n_cmp++; if (imem_rmask !== 8'h00) begin n_err++; $display("FAIL reset_rmask: got %h want 00", imem_rmask); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_mask !== 2'b00) begin n_err++; $display("FAIL reset_out_mask: got %b want 00", out_mask); end
    n_cmp++; if (out_branch_pred !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", out_branch_pred); end
    next();
    rst = 1'b0;
    #1;
    n_cmp++; if (pc_at_fetch !== RPC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_at_fetch, RPC); end
    n_cmp++; if (imem_addr !== RPC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
    n_cmp++; if (imem_rmask !== 8'hFF) begin n_err++; $display("FAIL reset_issue: got %h want ff", imem_rmask); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    mem_lat = 1;
    imem_ready = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== RPC) begin n_err++; $display("FAIL seq_addr0: got %h want %h", imem_addr, RPC); end
    for (int k = 1; k <= 6; k++) begin
      next();
      n_cmp++; if (imem_addr !== RPC + 32'(8 * k)) begin n_err++; $display("FAIL seq_addr k=%0d: got %h want %h", k, imem_addr, RPC + 32'(8 * k)); end
      if (k == 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL seq_startup_valid: got %b want 0", out_valid); end
      end else begin
        exp_pc = RPC + 32'(8 * (k - 2));
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid k=%0d: got %b want 1", k, out_valid); end
        n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL seq_out_pc k=%0d: got %h want %h", k, out_pc, exp_pc); end
        n_cmp++; if (out_mask !== 2'b11) begin n_err++; $display("FAIL seq_mask k=%0d: got %b want 11", k, out_mask); end
        n_cmp++; if (out_insts !== blk_data(exp_pc)) begin n_err++; $display("FAIL seq_insts k=%0d: got %h want %h", k, out_insts, blk_data(exp_pc)); end
      end
    end
    quiesce();
    $display("test_sequential done");
  endtask

  task automatic test_redirect();
    int fires = 0;
    int lat_j = 0;
    mem_lat = 4;
    redirect(32'h6000_0200);
    imem_ready = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (imem_rmask != '0 && imem_ready) fires++;
      next();
    end
    n_cmp++; if (fires !== 3) begin n_err++; $display("FAIL redir_inflight: got %0d want 3", fires); end
    branch_mispredict = 1'b1;
    branch_target = 32'h6000_0104;
    #1;
    n_cmp++; if (imem_rmask !== 8'h00) begin n_err++; $display("FAIL redir_no_issue: got %h want 00", imem_rmask); end
    next();
    branch_mispredict = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h6000_0100) begin n_err++; $display("FAIL redir_addr: got %h want 60000100", imem_addr); end
    n_cmp++; if (imem_rmask !== 8'hFF) begin n_err++; $display("FAIL redir_issue: got %h want ff", imem_rmask); end
    for (int j = 1; j <= 15; j++) begin
      if (out_valid === 1'b1) begin
        lat_j = j;
        break;
      end
      next();
    end
    n_cmp++; if (lat_j !== 6) begin n_err++; $display("FAIL redir_latency: got %0d want 6", lat_j); end
    n_cmp++; if (out_pc !== 32'h6000_0100) begin n_err++; $display("FAIL redir_out_pc: got %h want 60000100", out_pc); end
    n_cmp++; if (out_mask !== 2'b10) begin n_err++; $display("FAIL redir_mask: got %b want 10", out_mask); end
    n_cmp++; if (out_insts !== blk_data(32'h6000_0100)) begin n_err++; $display("FAIL redir_insts: got %h want %h", out_insts, blk_data(32'h6000_0100)); end
    n_cmp++; if (out_branch_pred !== 1'b0) begin n_err++; $display("FAIL redir_pred: got %b want 0", out_branch_pred); end
    next();
    n_cmp++; if (out_pc !== 32'h6000_0108) begin n_err++; $display("FAIL redir_next_pc: got %h want 60000108", out_pc); end
    n_cmp++; if (out_mask !== 2'b11) begin n_err++; $display("FAIL redir_next_mask: got %b want 11", out_mask); end
    quiesce();
    $display("test_redirect done");
  endtask

  task automatic test_bp_predict();
    mem_lat = 1;
    out_ready = 1'b0;
    redirect(32'h6000_0020);
    bp_taken = 1'b1;
    bp_slot = 1'b0;
    bp_target = 32'h6000_0400;
    imem_ready = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== 32'h6000_0020) begin n_err++; $display("FAIL bp_addr: got %h want 60000020", imem_addr); end
    next();
    bp_taken = 1'b0;
    imem_ready = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h6000_0400) begin n_err++; $display("FAIL bp_target_addr: got %h want 60000400", imem_addr); end
    next();
    next();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h6000_0020) begin n_err++; $display("FAIL bp_out_pc: got %h want 60000020", out_pc); end
    n_cmp++; if (out_mask !== 2'b01) begin n_err++; $display("FAIL bp_mask: got %b want 01", out_mask); end
    n_cmp++; if (out_branch_pred !== 1'b1) begin n_err++; $display("FAIL bp_pred: got %b want 1", out_branch_pred); end
    out_ready = 1'b1;
    next();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_pop: got %b want 0", out_valid); end
    // Predicted slot before the entry offset: not taken.
    redirect(32'h6000_0404);
    bp_taken = 1'b1;
    bp_slot = 1'b0;
    bp_target = 32'h6000_0800;
    imem_ready = 1'b1;
    #1;
    next();
    bp_taken = 1'b0;
    imem_ready = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h6000_0408) begin n_err++; $display("FAIL bp_behind_addr: got %h want 60000408", imem_addr); end
    next();
    next();
    n_cmp++; if (out_pc !== 32'h6000_0400) begin n_err++; $display("FAIL bp_behind_pc: got %h want 60000400", out_pc); end
    n_cmp++; if (out_mask !== 2'b10) begin n_err++; $display("FAIL bp_behind_mask: got %b want 10", out_mask); end
    n_cmp++; if (out_branch_pred !== 1'b0) begin n_err++; $display("FAIL bp_behind_pred: got %b want 0", out_branch_pred); end
    quiesce();
    $display("test_bp_predict done");
  endtask

  task automatic test_backpressure();
    int fires = 0;
    logic [31:0] exp_pc;
    mem_lat = 1;
    out_ready = 1'b0;
    redirect(32'h6000_1000);
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_rmask != '0 && imem_ready) fires++;
      next();
    end
    n_cmp++; if (fires !== 4) begin n_err++; $display("FAIL bkp_fires: got %0d want 4", fires); end
    n_cmp++; if (imem_rmask !== 8'h00) begin n_err++; $display("FAIL bkp_full_rmask: got %h want 00", imem_rmask); end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      exp_pc = 32'h6000_1000 + 32'(8 * j);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bkp_valid j=%0d: got %b want 1", j, out_valid); end
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL bkp_order j=%0d: got %h want %h", j, out_pc, exp_pc); end
      if (j == 1) begin
        n_cmp++; if (imem_rmask !== 8'hFF) begin n_err++; $display("FAIL bkp_resume_rmask: got %h want ff", imem_rmask); end
        n_cmp++; if (imem_addr !== 32'h6000_1020) begin n_err++; $display("FAIL bkp_resume_addr: got %h want 60001020", imem_addr); end
      end
      next();
    end
    quiesce();
    $display("test_backpressure done");
  endtask

  task automatic test_imem_stall();
    mem_lat = 1;
    out_ready = 1'b1;
    redirect(32'h6000_2000);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (imem_addr !== 32'h6000_2000) begin n_err++; $display("FAIL stall_addr i=%0d: got %h want 60002000", i, imem_addr); end
      n_cmp++; if (pc_at_fetch !== 32'h6000_2000) begin n_err++; $display("FAIL stall_pc i=%0d: got %h want 60002000", i, pc_at_fetch); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_alloc i=%0d: got %b want 0", i, out_valid); end
      next();
    end
    imem_ready = 1'b1;
    #1;
    next();
    imem_ready = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h6000_2008) begin n_err++; $display("FAIL stall_advance: got %h want 60002008", imem_addr); end
    next();
    n_cmp++; if (out_pc !== 32'h6000_2000) begin n_err++; $display("FAIL stall_out_pc: got %h want 60002000", out_pc); end
    next();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_single: got %b want 0", out_valid); end
    quiesce();
    $display("test_imem_stall done");
  endtask

  task automatic test_reset_inflight();
    int lat_j = 0;
    mem_lat = 4;
    out_ready = 1'b1;
    redirect(32'h6000_3000);
    imem_ready = 1'b1;
    #1;
    next();
    next();
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_rmask !== 8'h00) begin n_err++; $display("FAIL rst_rmask: got %h want 00", imem_rmask); end
    next();
    rst = 1'b0;
    #1;
    n_cmp++; if (pc_at_fetch !== RPC) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc_at_fetch, RPC); end
    n_cmp++; if (imem_addr !== RPC) begin n_err++; $display("FAIL rst_addr: got %h want %h", imem_addr, RPC); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    for (int j = 1; j <= 15; j++) begin
      if (out_valid === 1'b1) begin
        lat_j = j;
        break;
      end
      next();
    end
    n_cmp++; if (lat_j !== 6) begin n_err++; $display("FAIL rst_latency: got %0d want 6", lat_j); end
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL rst_first_pc: got %h want %h", out_pc, RPC); end
    n_cmp++; if (out_insts !== blk_data(RPC)) begin n_err++; $display("FAIL rst_first_insts: got %h want %h", out_insts, blk_data(RPC)); end
    quiesce();
    $display("test_reset_inflight done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_bp_predict();
    test_backpressure();
    test_imem_stall();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
